rgb_pwm_ctrl: RTL

- Fabric-side controller that produces CURREN, RGBLEDEN and the three PWM bits driving the iCE40UP RGB LED driver macro.
- Sequences reference-current power-up (settle time before enabling the driver) and generates three glitch-free PWM channels.
- Duty updates are double-buffered and take effect at the PWM period boundary; optional per-period linear fade toward the target.
- Sits between the SoC register bank (duty/enable writes) and the LED driver primitive.

---
 rtl/rgb_pwm_pkg.sv | 15 +
 rtl/rgb_pwm_chan.sv | 53 +++++
 rtl/rgb_pwm_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared types and defaults for the RGB LED PWM controller
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_SHUTDN = 2'd3
    } state_e;

    localparam int DEF_PWM_BITS      = 8;
    localparam int DEF_PRESCALE      = 94;
    localparam int DEF_SETTLE_CYCLES = 2400;

endpackage

// File: rtl/rgb_pwm_chan.sv
// rtl/rgb_pwm_chan.sv - one PWM channel: target/active duty registers and registered compare
module rgb_pwm_chan #(
    parameter int PWM_BITS = 8,
    parameter bit FADE     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic                wr_i,
    input  logic                boundary_i,
    input  logic                load_direct_i,
    input  logic                run_next_i,
    input  logic [PWM_BITS-1:0] cnt_next_i,
    output logic                pwm_o
);

    logic [PWM_BITS-1:0] target_q, target_d;
    logic [PWM_BITS-1:0] active_q, active_d;
    logic                pwm_q;

    // A write landing on the boundary cycle only reaches target_q afterwards,
    // so it takes effect one period later.
    always_comb begin
        target_d = wr_i ? duty_i : target_q;
        active_d = active_q;
        if (load_direct_i) begin
            active_d = target_q;
        end else if (boundary_i) begin
            if (!FADE) begin
                active_d = target_q;
            end else if (active_q < target_q) begin
                active_d = active_q + 1'b1;
            end else if (active_q > target_q) begin
                active_d = active_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            pwm_q    <= run_next_i && (cnt_next_i < active_d);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rtl/rgb_pwm_ctrl.sv - RGB LED driver sequencing FSM, settle timer, prescaler and PWM counter
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS      = DEF_PWM_BITS,
    parameter int PRESCALE      = DEF_PRESCALE,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int FADE          = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty0,
    input  logic [PWM_BITS-1:0] duty1,
    input  logic [PWM_BITS-1:0] duty2,
    input  logic                duty_wr,
    output logic                ready,
    output logic                curren,
    output logic                rgbleden,
    output logic                pwm0,
    output logic                pwm1,
    output logic                pwm2
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                curren_q, run_q;
    logic                run_now, run_next, pre_wrap, boundary, load_direct;

    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            ST_OFF:    if (en) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (!en) begin
                    state_d = ST_SHUTDN;
                end else if (settle_q == SET_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_RUN:    if (!en) state_d = ST_SHUTDN;
            default:   state_d = ST_OFF;
        endcase
    end

    assign run_now     = (state_q == ST_RUN);
    assign run_next    = (state_d == ST_RUN);
    assign pre_wrap    = (pre_q == PRE_MAX);
    assign boundary    = run_now && run_next && pre_wrap && (cnt_q == '1);
    assign load_direct = !run_now && run_next;

    // Counters only advance while staying in RUN; any other cycle parks them at 0.
    always_comb begin
        pre_d = '0;
        cnt_d = '0;
        if (run_now && run_next) begin
            pre_d = pre_wrap ? '0 : pre_q + 1'b1;
            cnt_d = pre_wrap ? cnt_q + 1'b1 : cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OFF;
            settle_q <= '0;
            pre_q    <= '0;
            cnt_q    <= '0;
            curren_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            curren_q <= (state_d != ST_OFF);
            run_q    <= run_next;
        end
    end

    assign curren   = curren_q;
    assign rgbleden = run_q;
    assign ready    = run_q;

    rgb_pwm_chan #(.PWM_BITS(PWM_BITS), .FADE(FADE != 0)) u_chan0 (
        .clk(clk), .rst(rst), .duty_i(duty0), .wr_i(duty_wr), .boundary_i(boundary),
        .load_direct_i(load_direct), .run_next_i(run_next), .cnt_next_i(cnt_d), .pwm_o(pwm0)
    );

    rgb_pwm_chan #(.PWM_BITS(PWM_BITS), .FADE(FADE != 0)) u_chan1 (
        .clk(clk), .rst(rst), .duty_i(duty1), .wr_i(duty_wr), .boundary_i(boundary),
        .load_direct_i(load_direct), .run_next_i(run_next), .cnt_next_i(cnt_d), .pwm_o(pwm1)
    );

    rgb_pwm_chan #(.PWM_BITS(PWM_BITS), .FADE(FADE != 0)) u_chan2 (
        .clk(clk), .rst(rst), .duty_i(duty2), .wr_i(duty_wr), .boundary_i(boundary),
        .load_direct_i(load_direct), .run_next_i(run_next), .cnt_next_i(cnt_d), .pwm_o(pwm2)
    );

endmodule
